// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type and index-width helper for fifo_wr_arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first asserted
// request starting at ptr and wrapping modulo N (N need not be a power of two).
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk offsets from farthest to nearest so the request closest to ptr wins.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one async-FIFO write port among
// N_REQ requesters, entirely in the FIFO write-clock domain.
// Optional macro FIFO_ARB_PKT_LOCK_EN: when defined, a grant is held for a whole
// packet (until req_last) with a MAX_BEATS watchdog; when undefined, every
// accepted beat releases the grant (per-beat round robin) and err_overlength is 0.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 16
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ*WIDTH-1:0]    req_data,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [WIDTH-1:0]          data_wr,
  output logic                      valid_wr,
  input  logic                      ready_wr,
  output logic                      last_wr,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      err_overlength
);

  localparam int IW = idx_w(N_REQ);

  arb_state_t                   state, state_nxt;
  logic [IW-1:0]                rr_ptr, next_ptr, pick_idx;
  logic                         pick_found, accept, release_gnt;
  logic [N_REQ-1:0][WIDTH-1:0]  lane_data;

  // Flat requester bus viewed as one lane per requester.
  assign lane_data = req_data;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign busy     = (state == BUSY);
  assign accept   = valid_wr & ready_wr;
  assign next_ptr = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);

  // Zero-latency forward of the granted lane; only the grant holder sees ready.
  always_comb begin
    valid_wr  = 1'b0;
    req_ready = '0;
    data_wr   = lane_data[grant_id];
    last_wr   = req_last[grant_id];
    if (state == BUSY) begin
      valid_wr            = req_valid[grant_id];
      req_ready[grant_id] = ready_wr;
    end
  end

`ifdef FIFO_ARB_PKT_LOCK_EN
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic [CW-1:0] beat_cnt;
  logic          at_limit;

  assign at_limit    = (beat_cnt == CW'(MAX_BEATS - 1));
  assign release_gnt = accept & (last_wr | at_limit);

  // Beats accepted under the current grant; cleared whenever the grant drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             beat_cnt <= '0;
    else if (release_gnt) beat_cnt <= '0;
    else if (accept)      beat_cnt <= beat_cnt + CW'(1);
  end

  // One-cycle flag when the watchdog, not req_last, ended the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_overlength <= 1'b0;
    else      err_overlength <= accept & ~last_wr & at_limit;
  end
`else
  logic unused_cfg;

  assign release_gnt    = accept;
  assign err_overlength = 1'b0;
  assign unused_cfg     = (MAX_BEATS > 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: grant on any request, drop on a releasing beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found)  state_nxt = BUSY;
      BUSY:    if (release_gnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture in the arbitration cycle; priority rotates past the released grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      if (state == IDLE && pick_found) grant_id <= pick_idx;
      if (state == BUSY && release_gnt) rr_ptr  <= next_ptr;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter (N_REQ=4, WIDTH=32,
// MAX_BEATS=16). Expectations switch on FIFO_ARB_PKT_LOCK_EN.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_valid, req_last, req_ready;
  logic [W-1:0]     data_wr;
  logic             valid_wr, ready_wr, last_wr;
  logic [1:0]       grant_id;
  logic             busy, err_overlength;

  int checks = 0;
  int errors = 0;

  // Requester model: packet length, beats sent, last mode (0 end, 1 every beat, 2 never)
  int len[N], sent[N], lmode[N];
  int stall_lo, stall_hi;

  // Per-cycle observation log and written-beat log
  logic           busy_l[64], vld_l[64], err_l[64];
  logic [W-1:0]   data_l[64];
  logic [N-1:0]   rdy_l[64];
  logic [1:0]     gnt_l[64];
  logic [W-1:0]   wq[$];
  logic           wlq[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BEATS(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_data       (req_data),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .data_wr        (data_wr),
    .valid_wr       (valid_wr),
    .ready_wr       (ready_wr),
    .last_wr        (last_wr),
    .grant_id       (grant_id),
    .busy           (busy),
    .err_overlength (err_overlength)
  );

  function automatic logic [W-1:0] mk(input int r, input int b);
    return {r[15:0], b[15:0]};
  endfunction

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; req_last = '0; req_data = '0; ready_wr = 1'b1;
    for (int i = 0; i < N; i++) begin len[i] = 0; sent[i] = 0; lmode[i] = 0; end
    stall_lo = -1; stall_hi = -1;
    wq.delete(); wlq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Drive the requester model for n cycles, logging DUT outputs mid-cycle.
  task automatic run(input int n);
    logic [N-1:0] acc;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i]       = (sent[i] < len[i]);
        req_data[i*W +: W] = mk(i, sent[i]);
        req_last[i]        = (lmode[i] == 1) || (lmode[i] == 0 && sent[i] == len[i] - 1);
      end
      ready_wr = !(c >= stall_lo && c <= stall_hi);
      #1;
      busy_l[c] = busy; vld_l[c] = valid_wr; err_l[c] = err_overlength;
      data_l[c] = data_wr; rdy_l[c] = req_ready; gnt_l[c] = grant_id;
      if (valid_wr && ready_wr) begin wq.push_back(data_wr); wlq.push_back(last_wr); end
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) sent[i] = sent[i] + 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '1; req_last = '1; req_data = '1; ready_wr = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (valid_wr !== 1'b0) begin errors++; $display("FAIL rst_valid_wr got %b want 0", valid_wr); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
    checks++; if (err_overlength !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err_overlength); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id got %0d want 0", grant_id); end
    do_reset();
    run(10);
    for (int c = 0; c < 10; c++) begin
      checks++; if (busy_l[c] !== 1'b0 || vld_l[c] !== 1'b0 || rdy_l[c] !== 4'b0)
        begin errors++; $display("FAIL idle_quiet cyc %0d got busy=%b vld=%b rdy=%b want 0/0/0000", c, busy_l[c], vld_l[c], rdy_l[c]); end
    end
  endtask

  task automatic test_packets();
    int eid[6], eb[6]; logic el[6]; int g2, ec;
`ifdef FIFO_ARB_PKT_LOCK_EN
    eid = '{0,0,0,2,2,2}; eb = '{0,1,2,0,1,2}; el = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1}; g2 = 5;
`else
    eid = '{0,2,0,2,0,2}; eb = '{0,0,1,1,2,2}; el = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1}; g2 = 3;
`endif
    do_reset();
    len[0] = 3; len[2] = 3;
    run(14);
    checks++; if (busy_l[0] !== 1'b0) begin errors++; $display("FAIL pkt_arb_cycle busy got %b want 0", busy_l[0]); end
    checks++; if (busy_l[1] !== 1'b1 || gnt_l[1] !== 2'd0) begin errors++; $display("FAIL pkt_first_grant got busy=%b gnt=%0d want 1/0", busy_l[1], gnt_l[1]); end
    checks++; if (busy_l[g2-1] !== 1'b0) begin errors++; $display("FAIL pkt_idle_gap got busy=%b want 0", busy_l[g2-1]); end
    checks++; if (busy_l[g2] !== 1'b1 || gnt_l[g2] !== 2'd2) begin errors++; $display("FAIL pkt_second_grant got busy=%b gnt=%0d want 1/2", busy_l[g2], gnt_l[g2]); end
    checks++; if (wq.size() !== 6) begin errors++; $display("FAIL pkt_beat_count got %0d want 6", wq.size()); end
    for (int k = 0; k < 6 && k < wq.size(); k++) begin
      checks++; if (wq[k] !== mk(eid[k], eb[k]) || wlq[k] !== el[k])
        begin errors++; $display("FAIL pkt_beat %0d got %h/%b want %h/%b", k, wq[k], wlq[k], mk(eid[k], eb[k]), el[k]); end
    end
    ec = 0; for (int c = 0; c < 14; c++) if (err_l[c] === 1'b1) ec++;
    checks++; if (ec !== 0) begin errors++; $display("FAIL pkt_no_err got %0d pulses want 0", ec); end
  endtask

  task automatic test_interleave();
    int eid[4], eb[4]; logic el[4]; int ec;
`ifdef FIFO_ARB_PKT_LOCK_EN
    eid = '{0,0,1,1}; eb = '{0,1,0,1}; el = '{1'b0,1'b1,1'b0,1'b1};
`else
    eid = '{0,1,0,1}; eb = '{0,0,1,1}; el = '{1'b0,1'b0,1'b1,1'b1};
`endif
    do_reset();
    len[0] = 2; len[1] = 2;
    run(12);
    checks++; if (wq.size() !== 4) begin errors++; $display("FAIL ilv_beat_count got %0d want 4", wq.size()); end
    for (int k = 0; k < 4 && k < wq.size(); k++) begin
      checks++; if (wq[k] !== mk(eid[k], eb[k]) || wlq[k] !== el[k])
        begin errors++; $display("FAIL ilv_beat %0d got %h/%b want %h/%b", k, wq[k], wlq[k], mk(eid[k], eb[k]), el[k]); end
    end
    ec = 0; for (int c = 0; c < 12; c++) if (err_l[c] === 1'b1) ec++;
    checks++; if (ec !== 0) begin errors++; $display("FAIL ilv_no_err got %0d pulses want 0", ec); end
  endtask

  task automatic test_all_four();
    int eid[5];
    eid = '{0,1,2,3,0};
    do_reset();
    for (int i = 0; i < N; i++) begin len[i] = 8; lmode[i] = 1; end
    run(10);
    checks++; if (wq.size() !== 5) begin errors++; $display("FAIL rr4_beat_count got %0d want 5", wq.size()); end
    for (int k = 0; k < 5 && k < wq.size(); k++) begin
      checks++; if (wq[k] !== mk(eid[k], k / 4))
        begin errors++; $display("FAIL rr4_order %0d got %h want %h", k, wq[k], mk(eid[k], k / 4)); end
    end
    for (int c = 0; c < 10; c += 2) begin
      checks++; if (busy_l[c] !== 1'b0 || busy_l[c+1] !== 1'b1 || gnt_l[c+1] !== 2'(eid[c/2]))
        begin errors++; $display("FAIL rr4_grant cyc %0d got busy=%b%b gnt=%0d want 01/%0d", c, busy_l[c], busy_l[c+1], gnt_l[c+1], eid[c/2]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    len[1] = 3; stall_lo = 2; stall_hi = 6;
    run(12);
    for (int c = 3; c <= 6; c++) begin
      checks++; if (busy_l[c] !== 1'b1 || gnt_l[c] !== 2'd1 || vld_l[c] !== 1'b1 || data_l[c] !== mk(1, 1) || rdy_l[c] !== 4'b0)
        begin errors++; $display("FAIL stall_hold cyc %0d got busy=%b gnt=%0d vld=%b data=%h rdy=%b want 1/1/1/%h/0000",
                                 c, busy_l[c], gnt_l[c], vld_l[c], data_l[c], rdy_l[c], mk(1, 1)); end
    end
    checks++; if (vld_l[7] !== 1'b1 || rdy_l[7] !== 4'b0010) begin errors++; $display("FAIL stall_resume got vld=%b rdy=%b want 1/0010", vld_l[7], rdy_l[7]); end
    checks++; if (wq.size() !== 3) begin errors++; $display("FAIL stall_beat_count got %0d want 3", wq.size()); end
    for (int k = 0; k < 3 && k < wq.size(); k++) begin
      checks++; if (wq[k] !== mk(1, k) || wlq[k] !== (k == 2))
        begin errors++; $display("FAIL stall_beat %0d got %h/%b want %h/%b", k, wq[k], wlq[k], mk(1, k), (k == 2)); end
    end
  endtask

  task automatic test_watchdog();
    int ec;
    do_reset();
    len[3] = 20; lmode[3] = 2;
`ifdef FIFO_ARB_PKT_LOCK_EN
    run(25);
    checks++; if (vld_l[16] !== 1'b1 || data_l[16] !== mk(3, 15)) begin errors++; $display("FAIL wd_beat16 got vld=%b data=%h want 1/%h", vld_l[16], data_l[16], mk(3, 15)); end
    checks++; if (err_l[17] !== 1'b1 || busy_l[17] !== 1'b0) begin errors++; $display("FAIL wd_release got err=%b busy=%b want 1/0", err_l[17], busy_l[17]); end
    checks++; if (busy_l[18] !== 1'b1 || gnt_l[18] !== 2'd3) begin errors++; $display("FAIL wd_rearb got busy=%b gnt=%0d want 1/3", busy_l[18], gnt_l[18]); end
    checks++; if (busy_l[22] !== 1'b1 || vld_l[22] !== 1'b0) begin errors++; $display("FAIL wd_hold_novalid got busy=%b vld=%b want 1/0", busy_l[22], vld_l[22]); end
    ec = 0; for (int c = 0; c < 25; c++) if (err_l[c] === 1'b1) ec++;
    checks++; if (ec !== 1) begin errors++; $display("FAIL wd_err_once got %0d pulses want 1", ec); end
`else
    run(42);
    checks++; if (busy_l[1] !== 1'b1 || busy_l[2] !== 1'b0) begin errors++; $display("FAIL wd_per_beat got busy=%b%b want 10", busy_l[1], busy_l[2]); end
    ec = 0; for (int c = 0; c < 42; c++) if (err_l[c] === 1'b1) ec++;
    checks++; if (ec !== 0) begin errors++; $display("FAIL wd_no_err got %0d pulses want 0", ec); end
`endif
    checks++; if (wq.size() !== 20) begin errors++; $display("FAIL wd_beat_count got %0d want 20", wq.size()); end
    for (int k = 0; k < 20 && k < wq.size(); k++) begin
      checks++; if (wq[k] !== mk(3, k) || wlq[k] !== 1'b0)
        begin errors++; $display("FAIL wd_beat %0d got %h/%b want %h/0", k, wq[k], wlq[k], mk(3, k)); end
    end
  endtask

  initial begin
    test_reset();
    test_packets();
    test_interleave();
    test_all_four();
    test_stall();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got time %0t want finish earlier", $time);
    $fatal(1);
  end

endmodule
